// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: decodes MIPS memory control codes, checks alignment and
// drives a big-endian word-wide req/ack memory port, with read-modify-write for sb/sh.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            MemRead,
    input  logic [1:0]            MemWrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam logic [2:0] MR_LW  = 3'b001;
    localparam logic [2:0] MR_LH  = 3'b010;
    localparam logic [2:0] MR_LHU = 3'b011;
    localparam logic [2:0] MR_LB  = 3'b100;
    localparam logic [2:0] MR_LBU = 3'b101;
    localparam logic [1:0] MW_SW  = 2'b01;
    localparam logic [1:0] MW_SH  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_DONE, S_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              mr_q, mr_d;
    logic [1:0]              offs_q, offs_d;
    logic                    half_q, half_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    req_valid;
    logic                    req_bad;

    // Big-endian lane select: byte offset 0 is the most significant byte.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] op,
                                                input logic [1:0] offs);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offs)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = offs[1] ? word[15:0] : word[31:16];
        case (op)
            MR_LH:   r = {{16{h[15]}}, h};
            MR_LHU:  r = {16'h0000, h};
            MR_LB:   r = {{24{b[7]}}, b};
            MR_LBU:  r = {24'h000000, b};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wd,
                                               input logic is_half, input logic [1:0] offs);
        logic [31:0] w;
        w = word;
        if (is_half) begin
            if (offs[1]) w[15:0] = wd;
            else         w[31:16] = wd;
        end else begin
            case (offs)
                2'd0:    w[31:24] = wd[7:0];
                2'd1:    w[23:16] = wd[7:0];
                2'd2:    w[15:8]  = wd[7:0];
                default: w[7:0]   = wd[7:0];
            endcase
        end
        return w;
    endfunction

    assign req_valid = start && ((MemRead != 3'b000) || (MemWrite != 2'b00));
    assign req_bad   = ((MemRead != 3'b000) && (MemWrite != 2'b00))
                    || (MemRead[2:1] == 2'b11)
                    || (((MemRead == MR_LW) || (MemWrite == MW_SW)) && (addr[1:0] != 2'b00))
                    || (((MemRead == MR_LH) || (MemRead == MR_LHU) || (MemWrite == MW_SH)) && addr[0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mr_q        <= 3'b000;
            offs_q      <= 2'b00;
            half_q      <= 1'b0;
            wdata_q     <= 16'h0000;
            rdata_q     <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            mr_q        <= mr_d;
            offs_q      <= offs_d;
            half_q      <= half_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mr_d        = mr_q;
        offs_d      = offs_q;
        half_d      = half_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mr_d       = MemRead;
                    offs_d     = addr[1:0];
                    half_d     = (MemWrite == MW_SH);
                    wdata_d    = wdata[15:0];
                    mem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                    if (req_bad) begin
                        state_d = S_FAULT;
                    end else if (MemRead != 3'b000) begin
                        state_d   = S_RD;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end else if (MemWrite == MW_SW) begin
                        state_d     = S_WR;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d   = S_RMW_RD;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    rdata_d   = load_extend(mem_rdata, mr_q, offs_q);
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            // Request stays high across the read-to-write turnaround.
            S_RMW_RD: begin
                if (mem_ack) begin
                    mem_wdata_d = merge_lane(mem_rdata, wdata_q, half_q, offs_q);
                    mem_we_d    = 1'b1;
                    state_d     = S_RMW_WR;
                end
            end
            S_WR, S_RMW_WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) || (state_q == S_FAULT);
    assign fault     = (state_q == S_FAULT);
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses against a word-array memory
// and an arithmetic model of the big-endian load/store rules.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [31:0] mem [16];
    logic [31:0] exp_rdata;
    int          n_compared;
    int          n_mismatch;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int access_size(input logic [2:0] mr, input logic [1:0] mw);
        if (mr == 3'd1 || mw == 2'd1) return 4;
        if (mr == 3'd2 || mr == 3'd3 || mw == 2'd2) return 2;
        return 1;
    endfunction

    function automatic bit is_rejected(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a);
        if (mr != 0 && mw != 0) return 1'b1;
        if (mr > 3'd5) return 1'b1;
        return (a % access_size(mr, mw)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] mr,
                                               input logic [31:0] a);
        int o;
        logic [31:0] v;
        o = int'(a % 4);
        case (mr)
            3'd2, 3'd3: begin
                v = (word >> (8 * (2 - o))) & 32'h0000_FFFF;
                if (mr == 3'd2 && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
            end
            3'd4, 3'd5: begin
                v = (word >> (8 * (3 - o))) & 32'h0000_00FF;
                if (mr == 3'd4 && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] mw, input logic [31:0] a);
        int size, o, sh;
        logic [31:0] mask;
        if (mw == 2'd1) return wd;
        size = (mw == 2'd2) ? 2 : 1;
        o    = int'(a % 4);
        sh   = 8 * (4 - size - o);
        mask = ((size == 2) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    // Issues one access at a negedge and plays the memory side until done, then steps to IDLE.
    task automatic applyStimulus(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a,
                                 input logic [31:0] wd, input int waits, input string tag);
        bit          rej, finished, saw_req;
        int          exp_done_cyc, phase, wait_cnt;
        logic [31:0] word, exp_word, exp_addr;
        logic        exp_we;
        rej      = is_rejected(mr, mw, a);
        word     = mem[a[5:2]];
        exp_word = model_store(word, wd, mw, a);
        exp_addr = a & 32'hFFFF_FFFC;
        if (rej)                         exp_done_cyc = 1;
        else if (mr != 0 || mw == 2'd1)  exp_done_cyc = 2 + waits;
        else                             exp_done_cyc = 3 + 2 * waits;
        if (!rej && mr != 0) exp_rdata = model_load(word, mr, a);

        start    = 1'b1;
        MemRead  = mr;
        MemWrite = mw;
        addr     = a;
        wdata    = wd;
        @(negedge clk);
        start    = 1'b0;
        MemRead  = 3'($urandom);
        MemWrite = 2'($urandom);
        addr     = $urandom;
        wdata    = $urandom;

        phase = 0; wait_cnt = 0; finished = 0; saw_req = 0;
        for (int cyc = 1; cyc <= 40 && !finished; cyc++) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            if (mem_req) begin
                saw_req = 1;
                exp_we  = (mw == 2'd1) || (mw != 2'd0 && phase == 1);
                checkOutput({tag, " mem_addr"}, mem_addr, exp_addr);
                checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
                if (wait_cnt == waits) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        checkOutput({tag, " mem_wdata"}, mem_wdata, exp_word);
                        mem[a[5:2]] = mem_wdata;
                    end else begin
                        mem_rdata = mem[a[5:2]];
                    end
                    phase++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (done) begin
                finished = 1;
                checkOutput({tag, " done_cycle"}, 32'(cyc), 32'(exp_done_cyc));
                checkOutput({tag, " fault"}, 32'(fault), 32'(rej));
                checkOutput({tag, " rdata"}, rdata, exp_rdata);
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checkOutput({tag, " completed"}, 32'(finished), 32'd1);
        checkOutput({tag, " req_issued"}, 32'(saw_req), 32'(!rej));
        checkOutput({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  r_mr;
        logic [1:0]  r_mw;
        n_compared = 0;
        n_mismatch = 0;
        exp_rdata  = 32'h0;
        reset      = 1'b0;
        start      = 1'b0;
        MemRead    = 3'b000;
        MemWrite   = 2'b00;
        addr       = 32'h0;
        wdata      = 32'h0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (2) @(negedge clk);
        checkOutput("reset rdata", rdata, 32'h0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset fault", 32'(fault), 32'd0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // A start with no operation selected leaves the unit idle.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("null_start busy", 32'(busy), 32'd0);
        checkOutput("null_start done", 32'(done), 32'd0);

        mem[4] = 32'hDEAD_BEEF;
        applyStimulus(3'd1, 2'd0, 32'h10, 32'h0, 0, "lw");
        checkOutput("lw const", rdata, 32'hDEAD_BEEF);
        mem[4] = 32'h1234_56F0;
        applyStimulus(3'd4, 2'd0, 32'h13, 32'h0, 0, "lb");
        checkOutput("lb const", rdata, 32'hFFFF_FFF0);
        applyStimulus(3'd5, 2'd0, 32'h13, 32'h0, 0, "lbu");
        checkOutput("lbu const", rdata, 32'h0000_00F0);
        mem[4] = 32'h8001_1234;
        applyStimulus(3'd2, 2'd0, 32'h10, 32'h0, 0, "lh");
        checkOutput("lh const", rdata, 32'hFFFF_8001);
        applyStimulus(3'd3, 2'd0, 32'h10, 32'h0, 0, "lhu");
        checkOutput("lhu const", rdata, 32'h0000_8001);
        mem[8] = 32'h1122_3344;
        applyStimulus(3'd0, 2'd3, 32'h21, 32'h0000_00AA, 2, "sb");
        checkOutput("sb const", mem[8], 32'h11AA_3344);

        applyStimulus(3'd0, 2'd1, 32'h22, 32'h5555_5555, 0, "fault_sw");
        applyStimulus(3'd2, 2'd0, 32'h11, 32'h0, 0, "fault_lh");
        applyStimulus(3'd1, 2'd1, 32'h10, 32'h0, 0, "fault_both");
        applyStimulus(3'd7, 2'd0, 32'h10, 32'h0, 0, "fault_mr7");
        checkOutput("fault rdata_held", rdata, 32'h0000_8001);

        // Start held high: the unit should accept every third cycle.
        mem[4]   = 32'hCAFE_0001;
        start    = 1'b1;
        MemRead  = 3'd1;
        MemWrite = 2'd0;
        addr     = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            mem_ack   = mem_req;
            mem_rdata = mem[4];
            checkOutput("b2b done", 32'(done), 32'((c % 3) == 2));
            checkOutput("b2b busy", 32'(busy), 32'((c % 3) != 0));
            if (c == 8) start = 1'b0;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("b2b idle", 32'(busy), 32'd0);
        checkOutput("b2b rdata", rdata, 32'hCAFE_0001);
        exp_rdata = 32'hCAFE_0001;

        // Reset during the write phase of a read-modify-write.
        start    = 1'b1;
        MemRead  = 3'd0;
        MemWrite = 2'd3;
        addr     = 32'h21;
        wdata    = 32'h0000_00BB;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = mem[8];
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("rst_mid in_write req", 32'(mem_req), 32'd1);
        checkOutput("rst_mid in_write we", 32'(mem_we), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid rdata", rdata, 32'h0);
        checkOutput("rst_mid busy", 32'(busy), 32'd0);
        checkOutput("rst_mid done", 32'(done), 32'd0);
        checkOutput("rst_mid mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mid mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mid mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mid mem_wdata", mem_wdata, 32'h0);
        reset   = 1'b1;
        mem_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("late_ack done", 32'(done), 32'd0);
            checkOutput("late_ack busy", 32'(busy), 32'd0);
        end
        mem_ack   = 1'b0;
        exp_rdata = 32'h0;

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 2))
                0: begin r_mr = 3'($urandom_range(1, 5)); r_mw = 2'd0; end
                1: begin r_mr = 3'd0; r_mw = 2'($urandom_range(1, 3)); end
                default: begin
                    r_mr = 3'($urandom_range(0, 7));
                    r_mw = 2'($urandom_range(0, 3));
                    if (r_mr == 3'd0 && r_mw == 2'd0) r_mr = 3'd1;
                end
            endcase
            applyStimulus(r_mr, r_mw, $urandom, $urandom, $urandom_range(0, 2), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting between the ALU result and a word-wide data memory in the MIPS datapath. It accepts one access per `start`, checks alignment and decodes the `MemRead`/`MemWrite` control codes. It drives a word-aligned request/acknowledge memory port, performing read-modify-write for `sb`/`sh`, and returns the sign- or zero-extended load value to the register write-back mux. `busy` stalls the pipeline while an access is in flight.

## Interface
- `ADDR_WIDTH`, default 32, byte-address width of `addr` and `mem_addr`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request an access; sampled only in IDLE.
- `MemRead`  in  3  000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 illegal.
- `MemWrite`  in  2  00 none, 01 sw, 10 sh, 11 sb.
- `addr`  in  ADDR_WIDTH  byte address (ALU result).
- `wdata`  in  32  store data (rt register value).
- `rdata`  out  32  extended load result; valid with `done`, held until the next load completes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of every accepted access.
- `fault`  out  1  one-cycle pulse coincident with `done` for a rejected access.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_WIDTH  word address, bits [1:0] always 0.
- `mem_wdata`  out  32  write word.
- `mem_rdata`  in  32  read word; valid with `mem_ack`.
- `mem_ack`  in  1  memory completion; ignored when `mem_req` is low.

## Operation
- Memory is big-endian: byte offset 0 is bits 31:24, offset 3 is bits 7:0. Halfword offset 0 is bits 31:16.
- In IDLE, `start` with both codes zero is ignored.
- On an accepted `start`, `addr`, `wdata` and both codes are captured. Inputs may change afterwards.
- A request is rejected when any of the following holds:
  - both codes are nonzero;
  - `MemRead` is 110 or 111;
  - lw/sw has `addr[1:0]` ≠ 0;
  - lh/lhu/sh has `addr[0]` ≠ 0.
- A rejected request goes to FAULT. No memory request is issued and `rdata` is unchanged.
- States and transitions:
  - IDLE → RD for a load.
  - IDLE → WR for sw.
  - IDLE → RMW_RD for sh/sb.
  - IDLE → FAULT for a rejected request.
  - RD → DONE on ack. The word is lane-extracted, extended and registered into `rdata`.
  - RMW_RD → RMW_WR on ack. The read word is captured and the `wdata` low byte (sb) or low halfword (sh) is merged into the addressed lane.
  - WR → DONE on ack; RMW_WR → DONE on ack.
  - DONE → IDLE and FAULT → IDLE unconditionally.
- Extension: lb/lh sign-extend from bit 7/15 of the lane; lbu/lhu zero-extend; lw passes the word through.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable for the whole request phase.
- Reset: state goes to IDLE and every output goes to 0 (`rdata`, `busy`, `done`, `fault`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`).
- Reset asserted mid-access aborts the access. `mem_req` is low after the reset edge, and a later `mem_ack` is ignored.

## Timing
- Cycle 0: `start` is sampled in IDLE.
- FAULT: `done` = `fault` = 1 in cycle 1; IDLE in cycle 2.
- Load or sw, zero-wait memory (ack in the first request cycle):
  - `mem_req` = 1 in cycle 1;
  - DONE with `done` = 1 in cycle 2;
  - IDLE in cycle 3.
- sh/sb, zero-wait memory:
  - read phase in cycle 1;
  - `mem_req` deasserts for zero cycles; the write phase starts in cycle 2 with `mem_we` = 1;
  - `done` in cycle 3.
- Each wait cycle (ack low while `mem_req` high) adds one cycle to its phase.
- `busy` = 1 from cycle 1 through the DONE/FAULT cycle inclusive.
- `start` during any non-IDLE state, including DONE, is ignored. Minimum spacing between accepted starts is 3 cycles.

## Test plan
- Reset: pull `reset` low for 2 cycles during RMW_WR → next cycle all outputs 0. An ack arriving afterwards causes no `done`; state stays IDLE.
- lw, `addr` 0x10, `mem_rdata` 0xDEADBEEF, ack immediate → `mem_addr` 0x10 with `mem_we` 0 in cycle 1; `done` and `rdata` 0xDEADBEEF in cycle 2.
- Loads from word 0x123456F0, each acked immediately:
  - lb @0x13 → `rdata` 0xFFFFFFF0;
  - lbu @0x13 → 0x000000F0;
  - lh @0x10 with word 0x80011234 → 0xFFFF8001;
  - lhu @0x10 with the same word → 0x00008001.
- sb, `addr` 0x21, `wdata` 0x000000AA, memory word 0x11223344, 2 wait cycles per phase → read of 0x20, then write of 0x11AA3344 to 0x20; `done` in cycle 7.
- Faults, each giving `done` = `fault` = 1 in cycle 1, `mem_req` never high, `rdata` unchanged:
  - sw @0x22;
  - lh @0x11;
  - `MemRead` 001 with `MemWrite` 01;
  - `MemRead` 111.
- Back-to-back: `start` held high continuously with lw → accepts in cycles 0, 3, 6. The `start` seen during DONE is ignored.
